// File: rtl/ext_lights_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ext_lights_pkg: mode/state encodings and counter sizing for ext_lights_multi
// Rev 1.0
// ----------------------------------------------------------------------------
package ext_lights_pkg;

  localparam logic [1:0] MODE_AUTO      = 2'b00;
  localparam logic [1:0] MODE_FORCE_ON  = 2'b01;
  localparam logic [1:0] MODE_FORCE_OFF = 2'b10;

  typedef enum logic [1:0] {
    S_OFF      = 2'd0,
    S_PEND_ON  = 2'd1,
    S_ON       = 2'd2,
    S_PEND_OFF = 2'd3
  } state_t;

  function automatic int cnt_width(input int persist);
    return (persist < 1) ? 1 : $clog2(persist + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ext_light_channel.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ext_light_channel: one light zone with hysteresis, persistence and override
// Rev 1.0
// ----------------------------------------------------------------------------
module ext_light_channel
  import ext_lights_pkg::*;
#(
  parameter int LUM_W      = 8,
  parameter int ON_THRESH  = 40,
  parameter int OFF_THRESH = 60,
  parameter int PERSIST    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [LUM_W-1:0] lum,
  input  logic [1:0]       mode,
  output logic             light,
  output logic             changed,
  output logic             light_next
);

  localparam int              CW    = cnt_width(PERSIST);
  localparam logic [CW:0]     P_LIM = (CW+1)'(PERSIST);
  localparam logic [LUM_W-1:0] ON_T  = LUM_W'(ON_THRESH);
  localparam logic [LUM_W-1:0] OFF_T = LUM_W'(OFF_THRESH);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [CW:0]   cnt_inc;
  logic          reached;

  assign cnt_inc = {1'b0, cnt} + 1'b1;
  // Switching happens on the PERSIST-th sample, so the counter never exceeds PERSIST-1.
  assign reached = (cnt_inc >= P_LIM);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (mode)
      MODE_FORCE_ON: begin
        state_nx = S_ON;
        cnt_nx   = '0;
      end
      MODE_FORCE_OFF: begin
        state_nx = S_OFF;
        cnt_nx   = '0;
      end
      default: begin
        if (valid) begin
          case (state)
            S_OFF, S_PEND_ON: begin
              if (lum < ON_T) begin
                state_nx = reached ? S_ON : S_PEND_ON;
                cnt_nx   = reached ? '0 : cnt_inc[CW-1:0];
              end else begin
                state_nx = S_OFF;
                cnt_nx   = '0;
              end
            end
            default: begin
              if (lum > OFF_T) begin
                state_nx = reached ? S_OFF : S_PEND_OFF;
                cnt_nx   = reached ? '0 : cnt_inc[CW-1:0];
              end else begin
                state_nx = S_ON;
                cnt_nx   = '0;
              end
            end
          endcase
        end
      end
    endcase
  end

  assign light_next = (state_nx == S_ON) || (state_nx == S_PEND_OFF);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_OFF;
      cnt     <= '0;
      light   <= 1'b0;
      changed <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      light   <= light_next;
      changed <= light_next ^ light;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ext_lights_multi.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ext_lights_multi: N_CH independent exterior light zones plus Any_on summary
// Rev 1.0
// ----------------------------------------------------------------------------
module ext_lights_multi
  import ext_lights_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int LUM_W      = 8,
  parameter int ON_THRESH  = 40,
  parameter int OFF_THRESH = 60,
  parameter int PERSIST    = 3
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  Lum_valid,
  input  logic [N_CH*LUM_W-1:0] Lum_sen,
  input  logic [2*N_CH-1:0]     Mode,
  output logic [N_CH-1:0]       Ext_light,
  output logic [N_CH-1:0]       Changed,
  output logic                  Any_on
);

  if ((OFF_THRESH < ON_THRESH) || (PERSIST < 1)) begin : g_bad_params
    $error("ext_lights_multi: need OFF_THRESH >= ON_THRESH and PERSIST >= 1");
  end

  logic [N_CH-1:0] light_next;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    ext_light_channel #(
      .LUM_W      (LUM_W),
      .ON_THRESH  (ON_THRESH),
      .OFF_THRESH (OFF_THRESH),
      .PERSIST    (PERSIST)
    ) u_ch (
      .clk        (CLK),
      .rst        (Reset),
      .valid      (Lum_valid),
      .lum        (Lum_sen[i*LUM_W +: LUM_W]),
      .mode       (Mode[2*i +: 2]),
      .light      (Ext_light[i]),
      .changed    (Changed[i]),
      .light_next (light_next[i])
    );
  end

  // Built from next-state bits so it lines up with Ext_light in the same cycle.
  always_ff @(posedge CLK) begin
    if (Reset) Any_on <= 1'b0;
    else       Any_on <= |light_next;
  end

endmodule
`default_nettype wire

// File: tb/tb_ext_lights_multi.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ext_lights_multi: directed vector bench for ext_lights_multi (4 zones)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_ext_lights_multi;

  logic        CLK;
  logic        Reset;
  logic        Lum_valid;
  logic [31:0] Lum_sen;
  logic [7:0]  Mode;
  logic [3:0]  Ext_light;
  logic [3:0]  Changed;
  logic        Any_on;

  int errors = 0;
  int checks = 0;

  ext_lights_multi dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .Lum_valid (Lum_valid),
    .Lum_sen   (Lum_sen),
    .Mode      (Mode),
    .Ext_light (Ext_light),
    .Changed   (Changed),
    .Any_on    (Any_on)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        valid;
    logic [31:0] lum;
    logic [7:0]  mode;
    logic [3:0]  light;
    logic [3:0]  chg;
    logic        any;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] pk(input logic [7:0] z0, z1, z2, z3);
    return {z3, z2, z1, z0};
  endfunction

  task automatic add(input logic r, v, input logic [31:0] l, input logic [7:0] m,
                     input logic [3:0] el, ec, input logic ea);
    vec_t t;
    t.rst = r; t.valid = v; t.lum = l; t.mode = m;
    t.light = el; t.chg = ec; t.any = ea;
    vecs.push_back(t);
  endtask

  task automatic step(input string name, input logic r, v, input logic [31:0] l,
                      input logic [7:0] m, input logic [3:0] el, ec, input logic ea);
    Reset = r; Lum_valid = v; Lum_sen = l; Mode = m;
    @(posedge CLK);
    #1;
    checks += 3;
    if (Ext_light !== el) begin
      errors++;
      $display("FAIL %s Ext_light: got %b want %b", name, Ext_light, el);
    end
    if (Changed !== ec) begin
      errors++;
      $display("FAIL %s Changed: got %b want %b", name, Changed, ec);
    end
    if (Any_on !== ea) begin
      errors++;
      $display("FAIL %s Any_on: got %b want %b", name, Any_on, ea);
    end
  endtask

  initial begin
    logic [31:0] idle;
    idle = pk(50, 50, 50, 50);
    Reset = 1'b1; Lum_valid = 1'b0; Lum_sen = idle; Mode = 8'h00;

    // Basic turn-on, hysteresis band clearing, simultaneous zones, reset dominance
    add(1, 0, idle,             8'h00, 4'b0000, 4'b0000, 0);
    add(0, 1, pk(90,50,50,50),  8'h00, 4'b0000, 4'b0000, 0);
    add(0, 1, pk(20,50,50,50),  8'h00, 4'b0000, 4'b0000, 0);
    add(0, 1, pk(20,50,50,50),  8'h00, 4'b0000, 4'b0000, 0);
    add(0, 1, pk(20,50,50,50),  8'h00, 4'b0001, 4'b0001, 1);
    add(0, 0, pk(90,90,90,90),  8'h00, 4'b0001, 4'b0000, 1);
    add(0, 1, pk(90,50,50,50),  8'h00, 4'b0001, 4'b0000, 1);
    add(0, 1, pk(90,50,50,50),  8'h00, 4'b0001, 4'b0000, 1);
    add(0, 1, pk(50,50,50,50),  8'h00, 4'b0001, 4'b0000, 1);
    add(0, 1, pk(90,50,50,50),  8'h00, 4'b0001, 4'b0000, 1);
    add(0, 1, pk(90,50,50,50),  8'h00, 4'b0001, 4'b0000, 1);
    add(0, 1, pk(90,50,50,50),  8'h00, 4'b0000, 4'b0001, 0);
    add(0, 0, idle,             8'h00, 4'b0000, 4'b0000, 0);
    add(0, 1, pk(10,10,10,10),  8'h00, 4'b0000, 4'b0000, 0);
    add(0, 1, pk(10,10,10,10),  8'h00, 4'b0000, 4'b0000, 0);
    add(0, 1, pk(10,10,10,10),  8'h00, 4'b1111, 4'b1111, 1);
    add(0, 0, idle,             8'h00, 4'b1111, 4'b0000, 1);
    add(1, 1, pk(10,10,10,10),  8'h55, 4'b0000, 4'b0000, 0);
    add(0, 1, pk(39,40,50,50),  8'h00, 4'b0000, 4'b0000, 0);

    foreach (vecs[i]) begin
      step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].valid, vecs[i].lum,
           vecs[i].mode, vecs[i].light, vecs[i].chg, vecs[i].any);
    end

    // Zone 1: count survives invalid cycles (zone 0 at count 1 from 39 is cleared)
    step("gap_a", 0, 1, pk(50,20,50,50), 8'h00, 4'b0000, 4'b0000, 0);
    for (int k = 0; k < 5; k++)
      step($sformatf("gap_idle%0d", k), 0, 0, pk(10,90,10,10), 8'h00, 4'b0000, 4'b0000, 0);
    step("gap_b", 0, 1, pk(50,20,50,50), 8'h00, 4'b0000, 4'b0000, 0);
    step("gap_c", 0, 1, pk(50,20,50,50), 8'h00, 4'b0010, 4'b0010, 1);

    // Zone 2: on, forced off, band sample keeps it off, then auto turn-on
    for (int k = 0; k < 3; k++)
      step($sformatf("z2_on%0d", k), 0, 1, pk(50,50,10,50), 8'h00,
           (k == 2) ? 4'b0110 : 4'b0010, (k == 2) ? 4'b0100 : 4'b0000, 1);
    step("z2_foff", 0, 0, idle, 8'h20, 4'b0010, 4'b0100, 1);
    step("z2_band", 0, 1, idle, 8'h00, 4'b0010, 4'b0000, 1);
    for (int k = 0; k < 3; k++)
      step($sformatf("z2_re%0d", k), 0, 1, pk(50,50,20,50), 8'h00,
           (k == 2) ? 4'b0110 : 4'b0010, (k == 2) ? 4'b0100 : 4'b0000, 1);

    // Forced-on while already on is silent; forced-on from off pulses; reserved = AUTO
    step("z1_fon", 0, 0, idle, 8'h04, 4'b0110, 4'b0000, 1);
    step("z0_fon", 0, 0, idle, 8'h01, 4'b0111, 4'b0001, 1);
    step("z0_auto", 0, 1, idle, 8'h00, 4'b0111, 4'b0000, 1);
    for (int k = 0; k < 3; k++)
      step($sformatf("z0_rsv%0d", k), 0, 1, pk(90,50,50,50), 8'h03,
           (k == 2) ? 4'b0110 : 4'b0111, (k == 2) ? 4'b0001 : 4'b0000, 1);

    // Zone 3: reset mid-count discards the partial count
    step("z3_p1", 0, 1, pk(50,50,50,20), 8'h00, 4'b0110, 4'b0000, 1);
    step("z3_p2", 0, 1, pk(50,50,50,20), 8'h00, 4'b0110, 4'b0000, 1);
    step("z3_rst", 1, 1, pk(50,50,50,20), 8'h00, 4'b0000, 4'b0000, 0);
    step("z3_q1", 0, 1, pk(50,50,50,20), 8'h00, 4'b0000, 4'b0000, 0);
    step("z3_q2", 0, 1, pk(50,50,50,20), 8'h00, 4'b0000, 4'b0000, 0);
    step("z3_q3", 0, 1, pk(50,50,50,20), 8'h00, 4'b1000, 4'b1000, 1);
    step("z3_hold", 0, 0, idle, 8'h00, 4'b1000, 4'b0000, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
